// File: rtl/model_pu_scheduler.sv
// -----------------------------------------------------------------------------
// model_pu_scheduler
//
// Shares one processing unit (PU) between REQUESTERS clients using round-robin
// arbitration. The owner gets LENGTH_IN PU steps. Each step is a one-cycle
// PU_START pulse followed by a wait for PU_READY. After the last step the owner
// receives a one-cycle DONE pulse.
//
// Ports:
//   CLK        : clock, all state changes on the rising edge
//   RST        : asynchronous active-low reset
//   REQ        : per-requester request level
//   LENGTH_IN  : number of PU steps, sampled when a grant is made
//   GRANT      : one-hot PU owner, all zero when idle
//   DONE       : one-cycle completion pulse to the owner
//   BUSY       : high whenever the scheduler is not idle
//   STEP_OUT   : 0-based index of the step in progress
//   PU_START   : one-cycle start pulse to the PU
//   PU_READY   : PU step-complete indication
//
// Every output is driven directly by a flop.
// -----------------------------------------------------------------------------
module model_pu_scheduler #(
    parameter int CONTROL_SIZE = 64,
    parameter int REQUESTERS   = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [REQUESTERS-1:0]   REQ,
    input  logic [CONTROL_SIZE-1:0] LENGTH_IN,
    output logic [REQUESTERS-1:0]   GRANT,
    output logic [REQUESTERS-1:0]   DONE,
    output logic                    BUSY,
    output logic [CONTROL_SIZE-1:0] STEP_OUT,
    output logic                    PU_START,
    input  logic                    PU_READY
);

    localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    // Wide enough to hold ptr + offset (at most 2*REQUESTERS-1) before the
    // modulo wrap.
    localparam int SUM_W = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        START_STATE = 2'd1,
        WAIT_STATE  = 2'd2,
        DONE_STATE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [CONTROL_SIZE-1:0] len_q, len_d;
    logic [CONTROL_SIZE-1:0] step_q, step_d;
    logic [REQUESTERS-1:0]   grant_q, grant_d;
    logic [REQUESTERS-1:0]   done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    pu_start_q, pu_start_d;

    // -------------------------------------------------------------------------
    // Round-robin arbitration
    // -------------------------------------------------------------------------
    // Candidate gi is the requester at distance gi+1 above the pointer, with
    // wrap-around. The lowest-numbered candidate that is requesting wins. This
    // makes the most recent owner (the pointer) the lowest priority.
    logic [REQUESTERS-1:0][IDX_W-1:0] cand_idx;
    logic [REQUESTERS-1:0]            cand_req;
    logic                             win_valid;
    logic [IDX_W-1:0]                 win_idx;

    generate
        for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_cand
            logic [SUM_W-1:0] sum_raw;

            assign sum_raw      = {1'b0, ptr_q} + SUM_W'(gi + 1);
            assign cand_idx[gi] = (sum_raw >= SUM_W'(REQUESTERS))
                                ? IDX_W'(sum_raw - SUM_W'(REQUESTERS))
                                : IDX_W'(sum_raw);
            assign cand_req[gi] = REQ[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        // Walk downward so that the nearest candidate is the last one written.
        for (int i = REQUESTERS - 1; i >= 0; i--) begin
            if (cand_req[i]) begin
                win_valid = 1'b1;
                win_idx   = cand_idx[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        len_d      = len_q;
        step_d     = step_q;
        grant_d    = grant_q;
        done_d     = '0;
        pu_start_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    owner_d = win_idx;
                    len_d   = LENGTH_IN;
                    step_d  = '0;
                    grant_d = REQUESTERS'(1) << win_idx;
                    if (LENGTH_IN == '0) begin
                        // A zero-length job completes without touching the PU.
                        // GRANT and DONE are asserted together for one cycle.
                        state_d = DONE_STATE;
                        done_d  = REQUESTERS'(1) << win_idx;
                        ptr_d   = win_idx;
                    end else begin
                        state_d    = START_STATE;
                        pu_start_d = 1'b1;
                    end
                end
            end

            START_STATE: begin
                // PU_READY is deliberately not looked at here. A READY that
                // arrives in the same cycle as START belongs to no step.
                state_d = WAIT_STATE;
            end

            WAIT_STATE: begin
                if (PU_READY) begin
                    // len_q is nonzero here, so len_q - 1 cannot wrap. This
                    // check also means STEP_OUT stops at the last index and
                    // never wraps, even for the maximum length.
                    if (step_q == len_q - CONTROL_SIZE'(1)) begin
                        state_d = DONE_STATE;
                        done_d  = grant_q;
                        ptr_d   = owner_q;
                    end else begin
                        step_d     = step_q + CONTROL_SIZE'(1);
                        state_d    = START_STATE;
                        pu_start_d = 1'b1;
                    end
                end
            end

            DONE_STATE: begin
                state_d = IDLE;
                grant_d = '0;
                step_d  = '0;
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
                step_d  = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            // Pointer starts at the top requester, so requester 0 is first.
            ptr_q      <= IDX_W'(REQUESTERS - 1);
            owner_q    <= '0;
            len_q      <= '0;
            step_q     <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            pu_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            len_q      <= len_d;
            step_q     <= step_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            pu_start_q <= pu_start_d;
        end
    end

    assign GRANT    = grant_q;
    assign DONE     = done_q;
    assign BUSY     = busy_q;
    assign STEP_OUT = step_q;
    assign PU_START = pu_start_q;

endmodule

// File: tb/tb_model_pu_scheduler.sv
// -----------------------------------------------------------------------------
// tb_model_pu_scheduler
//
// Bench for model_pu_scheduler. It runs randomized transactions against a
// transaction-level reference model, then directed cases for reset while the
// scheduler is running and for a maximum-length job.
// -----------------------------------------------------------------------------
module tb_model_pu_scheduler;

    localparam int CS = 64;
    localparam int NR = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [NR-1:0] REQ = '0;
    logic [CS-1:0] LENGTH_IN = '0;
    logic          PU_READY = 1'b0;
    logic [NR-1:0] GRANT;
    logic [NR-1:0] DONE;
    logic          BUSY;
    logic [CS-1:0] STEP_OUT;
    logic          PU_START;

    model_pu_scheduler #(
        .CONTROL_SIZE (CS),
        .REQUESTERS   (NR)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ       (REQ),
        .LENGTH_IN (LENGTH_IN),
        .GRANT     (GRANT),
        .DONE      (DONE),
        .BUSY      (BUSY),
        .STEP_OUT  (STEP_OUT),
        .PU_START  (PU_START),
        .PU_READY  (PU_READY)
    );

    always #5 CLK = ~CLK;

    int checks    = 0;
    int errors    = 0;
    int model_ptr = NR - 1;   // last owner; the next search starts above it
    int txn_no    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference arbitration: the first requesting index above the last
    // owner, with wrap-around.
    function automatic int pick(input logic [NR-1:0] r);
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (model_ptr + k) % NR;
            if (r[i]) return i;
        end
        return 0;
    endfunction

    task automatic check_active(input string tag, input logic [NR-1:0] g, input logic [NR-1:0] d,
                                input logic ps, input logic [CS-1:0] st);
        check_eq({tag, ".grant"}, 64'(GRANT), 64'(g));
        check_eq({tag, ".done"},  64'(DONE), 64'(d));
        check_eq({tag, ".start"}, 64'(PU_START), 64'(ps));
        check_eq({tag, ".step"},  64'(STEP_OUT), 64'(st));
        check_eq({tag, ".busy"},  64'(BUSY), 64'(1));
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".grant"}, 64'(GRANT), 64'(0));
        check_eq({tag, ".done"},  64'(DONE), 64'(0));
        check_eq({tag, ".start"}, 64'(PU_START), 64'(0));
        check_eq({tag, ".step"},  64'(STEP_OUT), 64'(0));
        check_eq({tag, ".busy"},  64'(BUSY), 64'(0));
    endtask

    // Runs n complete steps with READY returned right after each START. It
    // returns at the negedge of the START cycle of step n.
    task automatic quick_steps(input logic [NR-1:0] oh, input int n);
        for (int s = 0; s < n; s++) begin
            check_active("qs_start", oh, '0, 1'b1, CS'(s));
            PU_READY = 1'b0;
            @(negedge CLK);
            check_active("qs_wait", oh, '0, 1'b0, CS'(s));
            PU_READY = 1'b1;
            @(negedge CLK);
        end
        check_active("qs_start", oh, '0, 1'b1, CS'(n));
    endtask

    // Called at a negedge while the scheduler is idle. It returns at the
    // negedge of the idle cycle that follows DONE.
    task automatic run_txn(input logic [NR-1:0] req, input int len, input bit hold);
        int            w;
        int            d;
        logic [NR-1:0] oh;
        int            starts;
        starts    = 0;
        REQ       = req;
        LENGTH_IN = CS'(len);
        PU_READY  = hold;
        w         = pick(req);
        oh        = NR'(1) << w;
        @(negedge CLK);
        if (len == 0) begin
            check_active("zero_done", oh, oh, 1'b0, '0);
        end else begin
            for (int s = 0; s < len; s++) begin
                check_active("start", oh, '0, 1'b1, CS'(s));
                starts++;
                // Inputs that change mid-job must be ignored. A READY in a
                // START cycle is a stray and must not be counted.
                REQ       = NR'($urandom);
                LENGTH_IN = {$urandom(), $urandom()};
                PU_READY  = hold ? 1'b1 : 1'($urandom_range(0, 1));
                @(negedge CLK);
                d = hold ? 0 : $urandom_range(0, 2);
                repeat (d) begin
                    check_active("wait", oh, '0, 1'b0, CS'(s));
                    PU_READY = 1'b0;
                    @(negedge CLK);
                end
                check_active("wait", oh, '0, 1'b0, CS'(s));
                PU_READY = 1'b1;
                @(negedge CLK);
            end
            check_active("done", oh, oh, 1'b0, CS'(len - 1));
        end
        model_ptr = w;
        REQ       = NR'($urandom);
        PU_READY  = 1'b0;
        @(negedge CLK);
        check_idle("after_done");
        $display("txn %0d req=%b len=%0d hold=%0d winner=%0d starts=%0d", txn_no, req, len, hold, w, starts);
        txn_no++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            n;
        int            w;
        logic [NR-1:0] oh;

        // Reset state
        @(negedge CLK);
        check_idle("reset");
        @(negedge CLK);
        RST = 1'b1;

        // Directed cases from the test plan
        run_txn(4'b0001, 3, 1'b0);
        for (int i = 0; i < 5; i++) run_txn(4'b1111, 1, 1'b0);
        run_txn(4'b0100, 0, 1'b0);
        run_txn(4'b0010, 4, 1'b0);
        run_txn(4'b0001, 3, 1'b1);

        // Randomized transactions, sometimes separated by idle gaps
        for (int t = 0; t < 60; t++) begin
            n = $urandom_range(0, 2);
            REQ = '0;
            repeat (n) begin
                @(negedge CLK);
                check_idle("gap");
            end
            run_txn(NR'($urandom_range(1, (1 << NR) - 1)), $urandom_range(0, 5),
                    ($urandom_range(0, 9) == 0));
        end

        // Reset between clock edges while waiting in step 2 of 5
        run_txn(4'b0001, 1, 1'b0);      // leaves the pointer at 0
        REQ       = 4'b0010;
        LENGTH_IN = CS'(5);
        PU_READY  = 1'b0;
        w  = pick(REQ);
        oh = NR'(1) << w;
        @(negedge CLK);
        quick_steps(oh, 2);
        PU_READY = 1'b0;
        @(negedge CLK);
        check_active("pre_rst_wait", oh, '0, 1'b0, CS'(2));
        RST = 1'b0;
        #1;
        check_idle("async_rst");
        REQ = 4'b1001;
        @(negedge CLK);
        RST = 1'b1;
        model_ptr = NR - 1;
        run_txn(4'b1001, 1, 1'b0);      // requester 0 must win

        // Maximum length: steps advance and DONE stays low; reset ends the job
        REQ       = 4'b0001;
        LENGTH_IN = '1;
        @(negedge CLK);
        quick_steps(4'b0001, 3);
        RST = 1'b0;
        #1;
        check_idle("maxlen_rst");
        @(negedge CLK);
        RST = 1'b1;
        model_ptr = NR - 1;
        run_txn(4'b1000, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/model_pu_scheduler.md
Name: model_pu_scheduler

Overview:
Round-robin scheduler that shares one processing unit (PU) between REQUESTERS clients. It grants the PU to one requester at a time and issues single-cycle START pulses to the PU for a programmed number of time steps, advancing on each PU READY. After the last step it returns a one-cycle DONE to the owning requester. It sits between the NTM controller clients and the model_pu START/READY control pair.

Parameters:
CONTROL_SIZE, 64, width of the step-count and step-index buses
REQUESTERS, 4, number of requesters sharing the PU (>=2)

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  asynchronous active-low reset
REQ  input  REQUESTERS  per-requester request level
LENGTH_IN  input  CONTROL_SIZE  number of PU steps; sampled at arbitration
GRANT  output  REQUESTERS  one-hot owner of the PU; all zero when idle
DONE  output  REQUESTERS  one-cycle completion pulse to the owner
BUSY  output  1  high whenever the state is not IDLE
STEP_OUT  output  CONTROL_SIZE  index of the step in progress (0-based)
PU_START  output  1  one-cycle start pulse to the PU
PU_READY  input  1  PU step-complete indication

Behaviour:
- Reset (RST=0, asynchronous, effective mid-operation): state=IDLE; GRANT=0, DONE=0, BUSY=0, STEP_OUT=0, PU_START=0; length register=0. The round-robin pointer is set to REQUESTERS-1, so requester 0 has first priority.
- All outputs are registered.
- FSM states: IDLE, START_STATE, WAIT_STATE, DONE_STATE.
- IDLE with REQ!=0:
  - Choose the first set REQ bit searching upward from pointer+1, with modulo wrap.
  - Latch the winner index and LENGTH_IN. Set GRANT one-hot and STEP_OUT=0.
  - If LENGTH_IN=0, go to DONE_STATE. Otherwise go to START_STATE.
- IDLE with REQ=0: remain in IDLE.
- START_STATE: PU_START=1 for exactly this cycle, then go to WAIT_STATE unconditionally. PU_READY is ignored in this state.
- WAIT_STATE: PU_START=0. Wait any number of cycles for PU_READY=1.
  - If STEP_OUT = length-1, go to DONE_STATE.
  - Otherwise increment STEP_OUT and go to START_STATE.
- DONE_STATE: DONE[winner]=1 for one cycle with GRANT still asserted. The pointer is set to the winner index.
- Next cycle after DONE_STATE: GRANT=0, DONE=0, STEP_OUT=0, state=IDLE. At least one IDLE cycle separates grants.
- Latency:
  - REQ seen in IDLE at cycle c gives GRANT and state START_STATE at c+1, with PU_START high during c+1.
  - PU_READY at cycle k on the final step gives DONE high at k+1.
  - Minimum per step: 2 cycles (START_STATE, then WAIT_STATE with READY).
- REQ dropped mid-operation: ignored. The grant runs to completion and DONE still pulses.
- LENGTH_IN changed mid-operation: ignored, because the latched copy is used.
- A requester still holding REQ after its DONE is re-arbitrated behind the others, since the pointer has moved to it.
- PU_READY held continuously high: each WAIT_STATE cycle counts as one completion, so steps advance every 2 cycles.
- Length wrap: the length register and STEP_OUT are CONTROL_SIZE bits, unsigned. A length of 2^CONTROL_SIZE-1 is legal, and STEP_OUT never wraps.
- Simultaneous REQ bits: exactly one grant, chosen by the pointer rule. GRANT and DONE are never multi-hot.

Test Plan:
- Single requester: reset, REQ=0001, LENGTH_IN=3, PU model returns READY 2 cycles after each START.
  - Required: 3 PU_START pulses; STEP_OUT 0,1,2; DONE=0001 exactly one cycle after the third READY; then GRANT=0 and BUSY=0.
- Round-robin: after reset, REQ=1111 held with LENGTH_IN=1 and instant READY.
  - Required: grant order 0,1,2,3,0, each DONE pulsing once, one IDLE cycle between grants.
- Zero length: REQ=0100, LENGTH_IN=0.
  - Required: GRANT=0100 for 1 cycle with DONE=0100 in the same cycle, no PU_START, back to IDLE next cycle.
- Request withdrawal and ignored READY:
  - REQ=0010, LENGTH_IN=4; drop REQ after the first START; pulse PU_READY during a START_STATE cycle.
  - Required: the stray READY is not counted; exactly 4 STARTs; DONE=0010 is still issued.
- Asynchronous reset mid-run: RST low during WAIT_STATE of step 2 of 5, between clock edges.
  - Required: GRANT, BUSY, STEP_OUT and PU_START are 0 immediately.
  - Required after release with REQ=1000 and 0001 both set: requester 0 wins.
- READY held high: REQ=0001, LENGTH_IN=3, PU_READY=1 constantly.
  - Required: PU_START high every other cycle (3 pulses), DONE 6 cycles after GRANT rises.
